// File: rtl/dec_to_bin_entry_pkg.sv
// Shared types and constants for the decimal-digit entry block.
// Widths, digit limits and the entry FSM state encoding.
package dec_to_bin_entry_pkg;

  localparam int OUT_W      = 6;
  localparam int MAX_DIGITS = 2;
  localparam int MAX_VAL    = 63;
  localparam int ACC_W      = OUT_W + 4;

  localparam logic [3:0]       BCD_MAX     = 4'd9;
  localparam logic [1:0]       MAX_CNT     = 2'(MAX_DIGITS);
  localparam logic [ACC_W-1:0] MAX_VAL_ACC = ACC_W'(MAX_VAL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FULL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/dec_to_bin_entry_mac.sv
// Combinational decimal shift-in: acc*10 + digit via shifts, plus the range check.
// Computed four bits wider than the accumulator so the compare sees the true value.
module dec_digit_mac
  import dec_to_bin_entry_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_next,
  output logic             gt_max
);

  localparam logic [ACC_W+3:0] MAX_WIDE = (ACC_W + 4)'(MAX_VAL);

  logic [ACC_W+3:0] acc_wide_s;
  logic [ACC_W+3:0] sum_wide_s;

  assign acc_wide_s = {4'd0, acc};
  assign sum_wide_s = (acc_wide_s << 3) + (acc_wide_s << 1) + {{ACC_W{1'b0}}, digit};
  assign acc_next   = sum_wide_s[ACC_W-1:0];
  assign gt_max     = (sum_wide_s > MAX_WIDE);

endmodule

// File: rtl/dec_to_bin_entry.sv
// Decimal digit entry (tens first) into a held binary guess with valid/ack handoff.
// Define DEC2BIN_SAT_EN to clamp the accumulator at MAX_VAL on overflow instead of wrapping.
module dec_to_bin_entry
  import dec_to_bin_entry_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  output logic             digit_ready,
  input  logic             enter,
  input  logic             clear,
  output logic             bin_valid,
  output logic [OUT_W-1:0] bin_num,
  input  logic             bin_ack,
  output logic [1:0]       digit_cnt,
  output logic             ovf,
  output logic             err
);

  state_t           state_r, state_nxt_s;
  logic [ACC_W-1:0] acc_r, acc_nxt_s, mac_acc_s;
  logic [1:0]       cnt_r, cnt_nxt_s;
  logic [OUT_W-1:0] bin_num_r, bin_num_nxt_s;
  logic             bin_valid_r, bin_valid_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             err_r, err_nxt_s;
  logic             ready_r, ready_nxt_s;
  logic             mac_gt_s, xfer_s, good_s, take_s;

  dec_digit_mac u_mac (
    .acc      (acc_r),
    .digit    (digit),
    .acc_next (mac_acc_s),
    .gt_max   (mac_gt_s)
  );

  assign xfer_s = digit_valid & ready_r;
  assign good_s = (digit <= BCD_MAX);
  assign take_s = xfer_s & good_s;

  // Next-state and next-output decode for the entry FSM.
  always_comb begin
    state_nxt_s     = state_r;
    acc_nxt_s       = acc_r;
    cnt_nxt_s       = cnt_r;
    bin_num_nxt_s   = bin_num_r;
    bin_valid_nxt_s = bin_valid_r;
    ovf_nxt_s       = ovf_r;
    err_nxt_s       = 1'b0;
    if (clear) begin
      state_nxt_s     = ST_IDLE;
      acc_nxt_s       = {ACC_W{1'b0}};
      cnt_nxt_s       = 2'd0;
      bin_valid_nxt_s = 1'b0;
      ovf_nxt_s       = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_ACCUM, ST_FULL: begin
          if (take_s) begin
`ifdef DEC2BIN_SAT_EN
            acc_nxt_s = mac_gt_s ? MAX_VAL_ACC : mac_acc_s;
`else
            acc_nxt_s = mac_acc_s;
`endif
            cnt_nxt_s   = cnt_r + 2'd1;
            ovf_nxt_s   = ovf_r | mac_gt_s;
            state_nxt_s = (cnt_nxt_s == MAX_CNT) ? ST_FULL : ST_ACCUM;
          end else if (xfer_s) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = 1'b0;
          end
          // A digit landing with enter counts toward the committed value.
          if (enter && ((state_r != ST_IDLE) || take_s)) begin
            state_nxt_s     = ST_DONE;
            bin_num_nxt_s   = acc_nxt_s[OUT_W-1:0];
            bin_valid_nxt_s = 1'b1;
          end else begin
            bin_valid_nxt_s = bin_valid_r;
          end
        end
        ST_DONE: begin
          if (bin_ack) begin
            state_nxt_s     = ST_IDLE;
            acc_nxt_s       = {ACC_W{1'b0}};
            cnt_nxt_s       = 2'd0;
            bin_valid_nxt_s = 1'b0;
            ovf_nxt_s       = 1'b0;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s     = ST_IDLE;
          acc_nxt_s       = {ACC_W{1'b0}};
          cnt_nxt_s       = 2'd0;
          bin_valid_nxt_s = 1'b0;
          ovf_nxt_s       = 1'b0;
        end
      endcase
    end
    ready_nxt_s = (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACCUM);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      acc_r       <= {ACC_W{1'b0}};
      cnt_r       <= 2'd0;
      bin_num_r   <= {OUT_W{1'b0}};
      bin_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
      err_r       <= 1'b0;
      ready_r     <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      acc_r       <= acc_nxt_s;
      cnt_r       <= cnt_nxt_s;
      bin_num_r   <= bin_num_nxt_s;
      bin_valid_r <= bin_valid_nxt_s;
      ovf_r       <= ovf_nxt_s;
      err_r       <= err_nxt_s;
      ready_r     <= ready_nxt_s;
    end
  end

  assign digit_ready = ready_r;
  assign bin_valid   = bin_valid_r;
  assign bin_num     = bin_num_r;
  assign digit_cnt   = cnt_r;
  assign ovf         = ovf_r;
  assign err         = err_r;

endmodule

// File: tb/tb_dec_to_bin_entry.sv
// Directed, table-driven bench for dec_to_bin_entry, plus a hand-written reset-in-DONE sequence.
// Expected overflow result follows DEC2BIN_SAT_EN (63 clamped, else 75 mod 64 = 11).
module tb_dec_to_bin_entry;

`ifdef DEC2BIN_SAT_EN
  localparam logic [5:0] OVF_BN = 6'd63;
`else
  localparam logic [5:0] OVF_BN = 6'd11;
`endif

  typedef struct {
    logic       dv;
    logic [3:0] d;
    logic       en;
    logic       clr;
    logic       ack;
    logic       rdy;
    logic       bv;
    logic [5:0] bn;
    logic [1:0] cnt;
    logic       ovf;
    logic       err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       digit_valid = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       digit_ready;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       bin_valid;
  logic [5:0] bin_num;
  logic       bin_ack = 1'b0;
  logic [1:0] digit_cnt;
  logic       ovf;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t vecs[25];

  dec_to_bin_entry dut (
    .clk         (clk),
    .rst         (rst),
    .digit_valid (digit_valid),
    .digit       (digit),
    .digit_ready (digit_ready),
    .enter       (enter),
    .clear       (clear),
    .bin_valid   (bin_valid),
    .bin_num     (bin_num),
    .bin_ack     (bin_ack),
    .digit_cnt   (digit_cnt),
    .ovf         (ovf),
    .err         (err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic dv, logic [3:0] d, logic en, logic clr, logic ack,
                              logic rdy, logic bv, logic [5:0] bn, logic [1:0] cnt,
                              logic o, logic e);
    vec_t v;
    v.dv = dv; v.d = d; v.en = en; v.clr = clr; v.ack = ack;
    v.rdy = rdy; v.bv = bv; v.bn = bn; v.cnt = cnt; v.ovf = o; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dv, input logic [3:0] d, input logic en,
                       input logic clr, input logic ack);
    digit_valid = dv;
    digit       = d;
    enter       = en;
    clear       = clr;
    bin_ack     = ack;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             dv  d     en    clr   ack   rdy   bv    bn      cnt   ovf   err
    vecs[0]  = mk(1'b1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd1, 1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,   2'd2, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,   2'd2, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd42,  2'd2, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd42,  2'd2, 1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd1, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0,   2'd2, 1'b1, 1'b0);
    vecs[8]  = mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, OVF_BN, 2'd2, 1'b1, 1'b0);
    vecs[9]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b1);
    vecs[11] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd1, 1'b0, 1'b0);
    vecs[13] = mk(1'b1, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd39,  2'd2, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd39,  2'd2, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b0);
    vecs[16] = mk(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd1, 1'b0, 1'b0);
    vecs[17] = mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b0);
    vecs[18] = mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b0);
    vecs[19] = mk(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd1, 1'b0, 1'b0);
    vecs[20] = mk(1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b0);
    vecs[21] = mk(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd1, 1'b0, 1'b0);
    vecs[22] = mk(1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0,   2'd1, 1'b0, 1'b1);
    vecs[23] = mk(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 6'd21,  2'd2, 1'b0, 1'b0);
    vecs[24] = mk(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,   2'd0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_ready", 8'(digit_ready), 8'd1);
    chk("reset_bv",    8'(bin_valid),   8'd0);
    chk("reset_bn",    8'(bin_num),     8'd0);
    chk("reset_cnt",   8'(digit_cnt),   8'd0);
    chk("reset_ovf",   8'(ovf),         8'd0);
    chk("reset_err",   8'(err),         8'd0);

    for (int i = 0; i < 25; i++) begin
      drive(vecs[i].dv, vecs[i].d, vecs[i].en, vecs[i].clr, vecs[i].ack);
      chk($sformatf("v%0d_ready", i), 8'(digit_ready), 8'(vecs[i].rdy));
      chk($sformatf("v%0d_bv",    i), 8'(bin_valid),   8'(vecs[i].bv));
      chk($sformatf("v%0d_cnt",   i), 8'(digit_cnt),   8'(vecs[i].cnt));
      chk($sformatf("v%0d_ovf",   i), 8'(ovf),         8'(vecs[i].ovf));
      chk($sformatf("v%0d_err",   i), 8'(err),         8'(vecs[i].err));
      if (vecs[i].bv) begin
        chk($sformatf("v%0d_bn", i), 8'(bin_num), 8'(vecs[i].bn));
      end
    end

    // Reset while a result is held: outputs must drop before any clock edge.
    drive(1'b1, 4'd4, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("done_bv", 8'(bin_valid), 8'd1);
    chk("done_bn", 8'(bin_num),   8'd42);
    digit_valid = 1'b0;
    enter       = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_bv",  8'(bin_valid),   8'd0);
    chk("rst_async_bn",  8'(bin_num),     8'd0);
    chk("rst_async_cnt", 8'(digit_cnt),   8'd0);
    chk("rst_async_rdy", 8'(digit_ready), 8'd1);
    #2;
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("post_ack_bv",  8'(bin_valid),   8'd0);
    chk("post_ack_bn",  8'(bin_num),     8'd0);
    chk("post_ack_cnt", 8'(digit_cnt),   8'd0);
    chk("post_ack_rdy", 8'(digit_ready), 8'd1);
    drive(1'b1, 4'd8, 1'b1, 1'b0, 1'b0);
    chk("single_bv", 8'(bin_valid), 8'd1);
    chk("single_bn", 8'(bin_num),   8'd8);
    chk("single_cnt", 8'(digit_cnt), 8'd1);
    drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
